router_fsm: RTL and testbench

Packet-sequencing controller for the 1x3 router. It decodes the header address, waits for the destination FIFO to be free, and steps the register block through header load, payload load, FIFO-full stall, parity capture and parity check. It also drives the write enable and busy handshake toward the source. It sits between the source interface, the FIFO synchronizer (empty/full/soft-reset status) and the register block.

---
 rtl/router_fsm.sv | 146 ++++++++++++++
 tb/tb_router_fsm.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: decodes the header address,
// waits for a free destination FIFO and steps the register block through a packet.
module router_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    WAIT_TILL_EMPTY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_t;

  state_t     state, state_next;
  logic [1:0] addr_lat;
  logic       hdr_ok;
  logic       empty_hdr;
  logic       empty_lat;
  logic       soft_rst_sel;

  assign hdr_ok = pkt_valid && (data_in != 2'd3);

  always_comb begin
    empty_hdr = 1'b0;
    unique case (data_in)
      2'd0:    empty_hdr = fifo_empty_0;
      2'd1:    empty_hdr = fifo_empty_1;
      2'd2:    empty_hdr = fifo_empty_2;
      default: empty_hdr = 1'b0;
    endcase
  end

  always_comb begin
    empty_lat    = 1'b0;
    soft_rst_sel = 1'b0;
    unique case (addr_lat)
      2'd0: begin
        empty_lat    = fifo_empty_0;
        soft_rst_sel = soft_reset_0;
      end
      2'd1: begin
        empty_lat    = fifo_empty_1;
        soft_rst_sel = soft_reset_1;
      end
      2'd2: begin
        empty_lat    = fifo_empty_2;
        soft_rst_sel = soft_reset_2;
      end
      default: begin
        empty_lat    = 1'b0;
        soft_rst_sel = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= DECODE_ADDRESS;
      addr_lat <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE_ADDRESS && hdr_ok)
        addr_lat <= data_in;
    end
  end

  always_comb begin
    state_next = state;
    // A timeout on the selected port aborts the packet from any state but DA.
    if (state != DECODE_ADDRESS && soft_rst_sel) begin
      state_next = DECODE_ADDRESS;
    end else begin
      unique case (state)
        DECODE_ADDRESS: begin
          if (hdr_ok)
            state_next = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        WAIT_TILL_EMPTY: begin
          if (empty_lat)
            state_next = LOAD_FIRST_DATA;
        end
        LOAD_FIRST_DATA: state_next = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)
            state_next = FIFO_FULL_STATE;
          else if (!pkt_valid)
            state_next = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full)
            state_next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)
            state_next = DECODE_ADDRESS;
          else if (low_pkt_valid)
            state_next = LOAD_PARITY;
          else
            state_next = LOAD_DATA;
        end
        LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: state_next = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_addr   = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                    (state == LOAD_PARITY);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: each step advances one clock and compares the
// full output vector against the hand-derived decode of the expected state.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_addr, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // {detect_addr, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_WTE = 8'b0000_0001;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;

  router_fsm dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_addr   (detect_addr),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {detect_addr, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy};
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: outputs %b, expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    step(); step();
    chk("reset", O_DA);
    resetn = 1'b1;

    // addr 1 packet, 4 payload bytes
    pkt_valid = 1'b1; data_in = 2'd1;
    step(); chk("p1_lfd", O_LFD);
    step(); chk("p1_ld1", O_LD);
    step(); chk("p1_ld2", O_LD);
    step(); chk("p1_ld3", O_LD);
    step(); chk("p1_ld4", O_LD);
    pkt_valid = 1'b0;
    step(); chk("p1_lp", O_LP);
    step(); chk("p1_cpe", O_CPE);
    step(); chk("p1_da", O_DA);

    // addr 2 with busy FIFO 2; other FIFOs empty so a wrong select shows up
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    step(); chk("wte1", O_WTE);
    data_in = 2'd1;
    for (int i = 0; i < 4; i++) begin
      step(); chk("wte_hold", O_WTE);
    end
    fifo_empty_2 = 1'b1;
    step(); chk("wte_lfd", O_LFD);
    step(); chk("p2_ld", O_LD);

    // full stall, resume to LD
    fifo_full = 1'b1;
    step(); chk("ffs1", O_FFS);
    step(); chk("ffs2", O_FFS);
    step(); chk("ffs3", O_FFS);
    fifo_full = 1'b0;
    step(); chk("laf_a", O_LAF);
    step(); chk("laf_to_ld", O_LD);

    // full stall, low_pkt_valid routes LAF to LP; full at CPE returns to FFS
    fifo_full = 1'b1;
    step(); chk("ffs_b", O_FFS);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step(); chk("laf_b", O_LAF);
    step(); chk("laf_to_lp", O_LP);
    low_pkt_valid = 1'b0; fifo_full = 1'b1;
    step(); chk("lp_to_cpe_full", O_CPE);
    step(); chk("cpe_to_ffs", O_FFS);
    fifo_full = 1'b0;
    step(); chk("laf_c", O_LAF);
    parity_done = 1'b1; low_pkt_valid = 1'b1;
    step(); chk("laf_parity_done", O_DA);
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    // addr 3 and pkt_valid=0 are both ignored in DA
    pkt_valid = 1'b1; data_in = 2'd3;
    step(); chk("addr3", O_DA);
    pkt_valid = 1'b0; data_in = 2'd1;
    step(); chk("no_valid", O_DA);

    // port-0 packet: soft_reset_1 ignored, soft_reset_0 aborts
    pkt_valid = 1'b1; data_in = 2'd0;
    step(); chk("p3_lfd", O_LFD);
    step(); chk("p3_ld", O_LD);
    soft_reset_1 = 1'b1;
    step(); chk("sr1_ignored", O_LD);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step(); chk("sr0_abort", O_DA);
    soft_reset_0 = 1'b0; pkt_valid = 1'b0;
    step(); chk("sr0_idle", O_DA);

    // soft reset during LFD
    pkt_valid = 1'b1; data_in = 2'd0;
    step(); chk("p4_lfd", O_LFD);
    soft_reset_0 = 1'b1; pkt_valid = 1'b0;
    step(); chk("sr0_lfd", O_DA);
    soft_reset_0 = 1'b0;

    // pkt_valid falls as fifo_full rises: full wins
    pkt_valid = 1'b1; data_in = 2'd1;
    step(); chk("p5_lfd", O_LFD);
    step(); chk("p5_ld", O_LD);
    pkt_valid = 1'b0; fifo_full = 1'b1;
    step(); chk("sim_ffs", O_FFS);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step(); chk("sim_laf", O_LAF);
    step(); chk("sim_lp", O_LP);
    low_pkt_valid = 1'b0;
    step(); chk("sim_cpe", O_CPE);
    step(); chk("sim_da", O_DA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
